// File: rtl/count_sched.sv
// count_sched -- two-requester round-robin interval scheduler with a shared
// prescaled up-counter.
//
// A granted requester owns the counter for len*PRE+1 enabled cycles. The
// counter steps once every PRE enabled cycles and stops at the latched length.
// When the interval completes, the scheduler sends that requester a one-cycle
// done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   enable     run enable; low freezes count/prescaler and blocks new grants
//   req[1:0]   level requests, held until done or abort
//   len0/len1  interval lengths, sampled only on grant
//   gnt[1:0]   one-hot grant, high for the whole interval
//   busy       high while an interval is running or completing
//   done[1:0]  one-cycle completion pulse to the granted requester
//   count_out  shared 4-bit up-count
module count_sched #(
   parameter int PRE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] req,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   output logic [1:0] gnt,
   output logic       busy,
   output logic [1:0] done,
   output logic [3:0] count_out
);

   localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic          win, win_nx;
   logic          last, last_nx;
   logic [3:0]    tlen, tlen_nx;
   logic [3:0]    count, count_nx;
   logic [PW-1:0] presc, presc_nx;

   always_comb begin
      state_nx = state;
      win_nx   = win;
      last_nx  = last;
      tlen_nx  = tlen;
      count_nx = count;
      presc_nx = presc;
      case (state)
         IDLE: begin
            if (enable && (req != 2'b00)) begin
               // On a tie the requester that was not served last wins.
               win_nx   = (req == 2'b11) ? ~last : req[1];
               tlen_nx  = win_nx ? len1 : len0;
               count_nx = 4'd0;
               presc_nx = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (!req[win]) begin
               // Abort: the winner withdrew, so no done pulse is sent.
               state_nx = IDLE;
               last_nx  = win;
            end else if (count == tlen) begin
               state_nx = DONE;
            end else if (enable) begin
               if (presc == PRE_MAX) begin
                  presc_nx = '0;
                  count_nx = count + 4'd1;
               end else begin
                  presc_nx = presc + 1'b1;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
            last_nx  = win;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         win   <= 1'b0;
         last  <= 1'b1;
         tlen  <= 4'd0;
         count <= 4'd0;
         presc <= '0;
         gnt   <= 2'b00;
         done  <= 2'b00;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         win   <= win_nx;
         last  <= last_nx;
         tlen  <= tlen_nx;
         count <= count_nx;
         presc <= presc_nx;
         // The output flops are loaded from the next-state decode.
         // This keeps them aligned with the state register.
         gnt   <= (state_nx == RUN)  ? {win_nx, ~win_nx} : 2'b00;
         done  <= (state_nx == DONE) ? {win_nx, ~win_nx} : 2'b00;
         busy  <= (state_nx != IDLE);
      end
   end

   assign count_out = count;

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter: PRE, 1, prescale divisor; the counter advances once every PRE enabled clk cycles; legal range 1..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  global run enable; low freezes the count and prescaler, and blocks new grants.
REQ-005 req  input  2  per-requester request for an interval; level, held until done or abort.
REQ-006 len0  input  4  interval length for requester 0; sampled only on grant.
REQ-007 len1  input  4  interval length for requester 1; sampled only on grant.
REQ-008 gnt  output  2  one-hot grant; high for the whole interval.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 count_out  output  4  current shared 4-bit up-count.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE, enable=1, any req=1: select winner, latch its len into tlen, clear count and prescaler, set gnt[winner], go to RUN; gnt visible the cycle after req is sampled.
REQ-014 Arbitration: round-robin via 1-bit pointer last; both requesting → grant the requester that is not last; single requester → grant it.
REQ-015 RUN tick: prescaler reaches PRE-1 with enable=1 → prescaler←0 and count←count+1; otherwise, with enable=1, prescaler increments.
REQ-016 RUN: count==tlen at the start of a cycle → go to DONE; count is not incremented that cycle; len=0 → DONE on the first RUN cycle.
REQ-017 count SHALL never exceed tlen, so no 4-bit wrap occurs; len=15 yields 15 ticks.
REQ-018 DONE (exactly one cycle): done[winner]=1, gnt=0, last←winner, count held; next state IDLE.
REQ-019 Abort: req[winner] low in RUN → next state IDLE; gnt cleared; no done pulse; last←winner; count held.
REQ-020 enable low in RUN → count and prescaler freeze, gnt stays high, no abort; resumes where it stopped.
REQ-021 Req changes or len changes during RUN SHALL not alter tlen or winner.
REQ-022 Minimum one IDLE cycle between consecutive grants; back-to-back requests are served alternately.
REQ-023 enable low in IDLE → no grant, state stays IDLE.
REQ-024 Outputs SHALL be registered; done and gnt are never high in the same cycle.
REQ-025 Interval duration in RUN SHALL be len*PRE+1 cycles at enable=1.

Reset
REQ-026 reset SHALL override all activity, including mid-interval, and be sampled on the rising clk edge.
REQ-027 After reset: state=IDLE, gnt=00, done=00, busy=0, count_out=0, prescaler=0, tlen=0, last=1 so req0 wins the first tie.
REQ-028 Reset in RUN or DONE SHALL give no done pulse, and the first post-reset grant SHALL obey REQ-027.

Verification
REQ-029 PRE=1, reset, then req=01, len0=3 → gnt=01 next cycle; count_out 0,1,2,3; done=01 for one cycle after count=3; busy drops after DONE.
REQ-030 PRE=1, req=11 held, len0=2, len1=1 → grant order req0, req1, req0…; each done pulse to the correct bit; one IDLE cycle between grants.
REQ-031 PRE=4, req=10, len1=2 → count steps every 4 cycles; RUN lasts 9 cycles; done=10.
REQ-032 len0=0, req=01 → single RUN cycle with count_out=0, then done=01.
REQ-033 len0=15, enable low for 5 cycles at count=7 → count holds at 7 with gnt=01; on resume, done after count=15 with no wrap; req0 dropped mid-run in a repeat → no done, return to IDLE.
REQ-034 reset asserted at count=5 → next cycle all outputs 0; req=11 then grants req0 first.
